iommu_wsi_ig: RTL and testbench
===============================

Name: iommu_wsi_ig

Overview:
- Wired-signalled interrupt (WSI) generator sitting directly downstream of the IOMMU register map wrapper.
- Consumes the interrupt-related register fields (queue/HPM interrupt enables, icvec vector mapping, fctl.wsi, ipsr write-1-to-clear strobes) from reg2hw.
- Maintains the ipsr pending bits and returns them to the register map via hw2reg.
- Drives one level-sensitive wire per interrupt vector toward the platform interrupt controller.

Parameters:
- N_INT_VEC, 16, number of interrupt vectors/wires (power of two, 2..16).
- LOG2_VEC, $clog2(N_INT_VEC), width of each vector index field.
- HOLDOFF_CYCLES, 8, minimum cycles between a pending-bit clear and its next set (optional feature only; range 1..255).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous reset, active low.
- cq_cond_i  in  1  command-queue interrupt condition, level.
- fq_cond_i  in  1  fault-queue interrupt condition, level.
- hpm_cond_i  in  1  HPM counter-overflow interrupt condition, level.
- cq_ie_i  in  1  cqcsr.cie.
- fq_ie_i  in  1  fqcsr.fie.
- hpm_ie_i  in  1  HPM overflow interrupt enable.
- civ_i  in  LOG2_VEC  icvec.civ.
- fiv_i  in  LOG2_VEC  icvec.fiv.
- pmiv_i  in  LOG2_VEC  icvec.pmiv.
- wsi_en_i  in  1  fctl.wsi; global gate for the wires.
- ipsr_clr_i  in  3  one-cycle W1C strobes: bit0 cip, bit1 fip, bit2 pmip.
- ipsr_o  out  3  current pending bits {pmip, fip, cip} to hw2reg.d.
- ipsr_de_o  out  1  hw2reg data-enable; high for one cycle whenever ipsr_o changes value.
- wsi_o  out  N_INT_VEC  interrupt wires, level, active high.

Behaviour:
- One clock domain: clk_i. Asynchronous active-low reset: rst_ni.
- Reset values: ipsr_o=3'b000, ipsr_de_o=0, wsi_o=0, all internal counters 0.
- Source index: s=0 cq, 1 fq, 2 hpm. cond[s] and ie[s] are taken from the matching ports.
- Pending update, per source, each cycle, priority order:
  1. clr[s]=1 -> pend[s]<=0. Clear wins over a simultaneous set.
  2. Else cond[s]&ie[s] -> pend[s]<=1.
  3. Else hold.
- Condition is level-sensitive: if the cause persists after a clear, pend re-sets on the next cycle.
- Clearing ie[s] does not clear pend[s]. Only W1C or reset clears it.
- ipsr_de_o is registered: high in the cycle after pend_next!=pend, i.e. aligned with the new ipsr_o value.
- Wire mapping, registered, 1-cycle latency from pend:
  - wsi_o[v] <= wsi_en_i & OR over s of (pend[s] & vec[s]==v).
  - Several sources on one vector are ORed.
  - Vector field values >= N_INT_VEC are truncated to LOG2_VEC bits.
- Latency: cond rising -> ipsr_o set after 1 cycle -> wsi_o high after 2 cycles.
- wsi_en_i=0 forces wsi_o to 0 on the next edge. Pending tracking continues.
- icvec change while pending: the wire moves to the new vector on the next edge. No glitch beyond the one-cycle register boundary.
- Reset mid-operation clears all state immediately (asynchronous). Outputs stay 0 until conditions are re-sampled after reset release.

Optional Feature:
- Macro IOMMU_WSI_HOLDOFF_EN.
- Defined:
  - Per-source 8-bit holdoff counter, loaded with HOLDOFF_CYCLES on a clear of pend[s].
  - Decrements each cycle to 0.
  - Set of pend[s] is suppressed while its counter is non-zero.
  - A condition still present at expiry sets pend on the cycle after the counter reaches 0.
  - A clear during holdoff reloads the counter.
- Not defined: no counters; set behaviour exactly as in Behaviour (re-set 1 cycle after clear).

Test Plan:
- Reset, then cq_cond_i=1, cq_ie_i=1, civ_i=3, wsi_en_i=1 -> ipsr_o=3'b001 and ipsr_de_o=1 at cycle 1; wsi_o=16'h0008 at cycle 2.
- fiv_i=5 and pmiv_i=5, pulse fq_cond_i and hpm_cond_i for 1 cycle each; W1C fip only -> wsi_o[5] stays 1 until pmip is also cleared, then 0 one cycle later.
- cq pending; drive ipsr_clr_i=3'b001 and cq_cond_i=1 in the same cycle -> cip=0 that cycle, back to 1 the next cycle, ipsr_de_o pulses twice. With IOMMU_WSI_HOLDOFF_EN and HOLDOFF_CYCLES=8 -> cip stays 0 for 8 cycles, then re-sets.
- fip pending, wsi_en_i toggled 1->0->1 -> wsi_o[fiv] follows with 1-cycle lag; ipsr_o[1] stays 1 throughout.
- fq_ie_i=0 with fq_cond_i=1 -> ipsr_o=0, wsi_o=0. Setting fq_ie_i=1 -> fip set the next cycle.
- Assert rst_ni low mid-cycle with all three pending -> ipsr_o, wsi_o, ipsr_de_o read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iommu_wsi_ig.sv
// iommu_wsi_ig: wired-signalled interrupt generator for the IOMMU register map.
// Tracks the cip/fip/pmip pending bits, reports them back through hw2reg and
// drives one level-sensitive wire per interrupt vector.
// Optional macro IOMMU_WSI_HOLDOFF_EN adds a per-source re-set holdoff counter.
module iommu_wsi_ig #(
    parameter int N_INT_VEC      = 16,
    parameter int LOG2_VEC       = $clog2(N_INT_VEC),
    parameter int HOLDOFF_CYCLES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cq_cond_i,
    input  logic                 fq_cond_i,
    input  logic                 hpm_cond_i,
    input  logic                 cq_ie_i,
    input  logic                 fq_ie_i,
    input  logic                 hpm_ie_i,
    input  logic [LOG2_VEC-1:0]  civ_i,
    input  logic [LOG2_VEC-1:0]  fiv_i,
    input  logic [LOG2_VEC-1:0]  pmiv_i,
    input  logic                 wsi_en_i,
    input  logic [2:0]           ipsr_clr_i,
    output logic [2:0]           ipsr_o,
    output logic                 ipsr_de_o,
    output logic [N_INT_VEC-1:0] wsi_o
);

    if (N_INT_VEC < 2 || N_INT_VEC > 16 || (N_INT_VEC & (N_INT_VEC - 1)) != 0 ||
        HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_param_err
        $error("iommu_wsi_ig: illegal parameter value");
    end

    // Source order everywhere: bit0 cq, bit1 fq, bit2 hpm.
    logic [2:0]           cond;
    logic [2:0]           ie;
    logic [2:0]           set_ok;
    logic [2:0]           pend_d;
    logic [2:0]           pend_q;
    logic                 de_d;
    logic                 de_q;
    logic [N_INT_VEC-1:0] wsi_d;
    logic [N_INT_VEC-1:0] wsi_q;
    logic [LOG2_VEC-1:0]  vec [3];

    assign cond   = {hpm_cond_i, fq_cond_i, cq_cond_i};
    assign ie     = {hpm_ie_i, fq_ie_i, cq_ie_i};
    assign vec[0] = civ_i;
    assign vec[1] = fiv_i;
    assign vec[2] = pmiv_i;

`ifdef IOMMU_WSI_HOLDOFF_EN
    logic [7:0] hold_d [3];
    logic [7:0] hold_q [3];

    // Holdoff counters: reload on every clear, count down to zero, block sets while non-zero.
    always_comb begin
        set_ok = '1;
        for (int s = 0; s < 3; s++) begin
            hold_d[s] = ipsr_clr_i[s] ? 8'(HOLDOFF_CYCLES) :
                        (hold_q[s] != 8'd0) ? hold_q[s] - 8'd1 : 8'd0;
            set_ok[s] = (hold_q[s] == 8'd0);
        end
    end

    // Holdoff counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 3; s++) hold_q[s] <= '0;
        end else begin
            for (int s = 0; s < 3; s++) hold_q[s] <= hold_d[s];
        end
    end
`else
    assign set_ok = '1;
`endif

    // Pending next state: W1C clear beats a simultaneous level-sensitive set.
    always_comb begin
        pend_d = pend_q;
        for (int s = 0; s < 3; s++) begin
            pend_d[s] = ipsr_clr_i[s] ? 1'b0 :
                        (cond[s] & ie[s] & set_ok[s]) ? 1'b1 : pend_q[s];
        end
        de_d = (pend_d != pend_q);
    end

    // Wire decode from the registered pending bits, gated by fctl.wsi.
    always_comb begin
        wsi_d = '0;
        for (int s = 0; s < 3; s++) begin
            if (pend_q[s]) wsi_d[vec[s]] = 1'b1;
        end
        if (!wsi_en_i) wsi_d = '0;
    end

    // State registers: pending bits, data-enable pulse and interrupt wires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            de_q   <= 1'b0;
            wsi_q  <= '0;
        end else begin
            pend_q <= pend_d;
            de_q   <= de_d;
            wsi_q  <= wsi_d;
        end
    end

    assign ipsr_o    = pend_q;
    assign ipsr_de_o = de_q;
    assign wsi_o     = wsi_q;

endmodule

// File: tb/tb_iommu_wsi_ig.sv
// tb_iommu_wsi_ig: directed and randomized checks of iommu_wsi_ig against a behavioural model.
module tb_iommu_wsi_ig;
    localparam int N = 16;
    localparam int LV = 4;
    localparam int H = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cq_cond = 1'b0, fq_cond = 1'b0, hpm_cond = 1'b0;
    logic          cq_ie = 1'b0, fq_ie = 1'b0, hpm_ie = 1'b0;
    logic [LV-1:0] civ = '0, fiv = '0, pmiv = '0;
    logic          wsi_en = 1'b0;
    logic [2:0]    clr = '0;
    logic [2:0]    ipsr;
    logic          ipsr_de;
    logic [N-1:0]  wsi;

    int checks = 0;
    int failures = 0;

    logic [2:0]   e_pend = '0;
    logic         e_de = 1'b0;
    logic [N-1:0] e_wsi = '0;
    int           hold [3] = '{0, 0, 0};

    iommu_wsi_ig #(.N_INT_VEC(N), .HOLDOFF_CYCLES(H)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cq_cond_i(cq_cond), .fq_cond_i(fq_cond), .hpm_cond_i(hpm_cond),
        .cq_ie_i(cq_ie), .fq_ie_i(fq_ie), .hpm_ie_i(hpm_ie),
        .civ_i(civ), .fiv_i(fiv), .pmiv_i(pmiv),
        .wsi_en_i(wsi_en), .ipsr_clr_i(clr),
        .ipsr_o(ipsr), .ipsr_de_o(ipsr_de), .wsi_o(wsi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        e_pend = '0;
        e_de = 1'b0;
        e_wsi = '0;
        for (int s = 0; s < 3; s++) hold[s] = 0;
    endtask

    // Advance one clock: predict outputs from the spec rules, then compare after the edge.
    task automatic tick();
        logic [2:0]   c, ie, np;
        logic [N-1:0] nw;
        int           vec [3];
        int           nh [3];
        bit           blk;
        c = {hpm_cond, fq_cond, cq_cond};
        ie = {hpm_ie, fq_ie, cq_ie};
        vec[0] = int'(civ);
        vec[1] = int'(fiv);
        vec[2] = int'(pmiv);
        np = e_pend;
        for (int s = 0; s < 3; s++) begin
            blk = 1'b0;
`ifdef IOMMU_WSI_HOLDOFF_EN
            blk = hold[s] > 0;
`endif
            nh[s] = clr[s] ? H : (hold[s] > 0 ? hold[s] - 1 : 0);
            if (clr[s]) np[s] = 1'b0;
            else if (c[s] && ie[s] && !blk) np[s] = 1'b1;
        end
        nw = '0;
        for (int v = 0; v < N; v++)
            for (int s = 0; s < 3; s++)
                if (wsi_en && e_pend[s] && vec[s] == v) nw[v] = 1'b1;
        @(negedge clk);
        e_de = (np != e_pend);
        e_pend = np;
        e_wsi = nw;
        for (int s = 0; s < 3; s++) hold[s] = nh[s];
        chk("ipsr", 32'(ipsr), 32'(e_pend));
        chk("ipsr_de", 32'(ipsr_de), 32'(e_de));
        chk("wsi", 32'(wsi), 32'(e_wsi));
    endtask

    task automatic async_reset_check();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ipsr", 32'(ipsr), 32'h0);
        chk("rst_de", 32'(ipsr_de), 32'h0);
        chk("rst_wsi", 32'(wsi), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_ipsr", 32'(ipsr), 32'h0);
        chk("reset_de", 32'(ipsr_de), 32'h0);
        chk("reset_wsi", 32'(wsi), 32'h0);
        rst_n = 1'b1;
        model_reset();

        // Basic latency: cq on vector 3.
        cq_cond = 1; cq_ie = 1; civ = 3; wsi_en = 1;
        tick();
        chk("lat_ipsr", 32'(ipsr), 32'h1);
        chk("lat_de", 32'(ipsr_de), 32'h1);
        tick();
        chk("lat_wsi", 32'(wsi), 32'h0008);
        chk("lat_de_low", 32'(ipsr_de), 32'h0);

        // Two sources sharing vector 5.
        fiv = 5; pmiv = 5; fq_ie = 1; hpm_ie = 1;
        fq_cond = 1;
        tick();
        fq_cond = 0; hpm_cond = 1;
        tick();
        hpm_cond = 0;
        chk("share_ipsr", 32'(ipsr), 32'h7);
        tick();
        chk("share_wsi", 32'(wsi), 32'h0028);
        clr = 3'b010;
        tick();
        clr = 3'b000;
        chk("fip_clr_ipsr", 32'(ipsr), 32'h5);
        tick();
        chk("pmip_holds_wire", 32'(wsi), 32'h0028);
        clr = 3'b100;
        tick();
        clr = 3'b000;
        tick();
        chk("wire_drops", 32'(wsi), 32'h0008);

        // Clear and set in the same cycle.
        clr = 3'b001;
        tick();
        clr = 3'b000;
        chk("clr_wins", 32'(ipsr[0]), 32'h0);
        chk("clr_de", 32'(ipsr_de), 32'h1);
        tick();
`ifndef IOMMU_WSI_HOLDOFF_EN
        chk("reset_after_clr", 32'(ipsr[0]), 32'h1);
        chk("reset_de", 32'(ipsr_de), 32'h1);
`endif
        repeat (12) tick();

        // wsi_en toggling with fip pending.
        fq_cond = 1;
        tick();
        fq_cond = 0;
        tick();
        wsi_en = 0;
        tick();
        chk("en_off_wsi", 32'(wsi), 32'h0);
        chk("en_off_fip", 32'(ipsr[1]), 32'h1);
        wsi_en = 1;
        tick();
        chk("en_on_wsi", 32'(wsi), 32'h0028);

        // Disabled source does not pend.
        clr = 3'b111; cq_cond = 0;
        tick();
        clr = 3'b000; fq_ie = 0; fq_cond = 1;
        repeat (H + 2) tick();
        chk("ie_off_ipsr", 32'(ipsr), 32'h0);
        chk("ie_off_wsi", 32'(wsi), 32'h0);
        fq_ie = 1;
        tick();
        chk("ie_on_fip", 32'(ipsr), 32'h2);

        // Asynchronous reset with all three pending.
        cq_cond = 1; hpm_cond = 1; cq_ie = 1; hpm_ie = 1;
        repeat (2) tick();
        chk("all_pend", 32'(ipsr), 32'h7);
        async_reset_check();
        repeat (2) tick();

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            cq_cond = $urandom_range(0, 2) == 0;
            fq_cond = $urandom_range(0, 2) == 0;
            hpm_cond = $urandom_range(0, 2) == 0;
            cq_ie = $urandom_range(0, 5) != 0;
            fq_ie = $urandom_range(0, 5) != 0;
            hpm_ie = $urandom_range(0, 5) != 0;
            if ($urandom_range(0, 15) == 0) civ = LV'($urandom);
            if ($urandom_range(0, 15) == 0) fiv = LV'($urandom);
            if ($urandom_range(0, 15) == 0) pmiv = LV'($urandom);
            wsi_en = $urandom_range(0, 9) != 0;
            clr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            if (i % 500 == 250) async_reset_check();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
